// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit width, PE credit limit, default buffer depth, flit type.
package noc_pkg;

  localparam int unsigned FLIT_W     = 20;
  localparam int unsigned PE_CREDITS = 7;
  localparam int unsigned DEPTH      = 8;

  typedef logic [FLIT_W-1:0] flit_t;

endpackage

// File: rtl/noc_flit_fifo.sv
// Synchronous first-word-fall-through FIFO. The head entry is visible on rdata whenever
// empty is low. The caller guarantees push is never asserted while full without a pop.
module noc_flit_fifo
  import noc_pkg::*;
#(
  parameter int unsigned FLIT_W = noc_pkg::FLIT_W,
  parameter int unsigned DEPTH  = noc_pkg::DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [FLIT_W-1:0]        wdata,
  output logic [FLIT_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned OccW = PtrW + 1;
  localparam logic [PtrW-1:0] PtrOne = PtrW'(1);
  localparam logic [OccW-1:0] OccOne = OccW'(1);
  localparam logic [OccW-1:0] OccMax = OccW'(DEPTH);

  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0]   occ_q, occ_d;

  // Pointer and occupancy next state; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrOne;
    if (pop)  rd_ptr_d = rd_ptr_q + PtrOne;
    if (push && !pop)      occ_d = occ_q + OccOne;
    else if (pop && !push) occ_d = occ_q - OccOne;
  end

  // Control state with synchronous reset; buffered contents are abandoned, not cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage array, written at the write pointer on an accepted push.
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata     = mem_q[rd_ptr_q];
  assign full      = (occ_q == OccMax);
  assign empty     = (occ_q == '0);
  assign occupancy = occ_q;

endmodule

// File: rtl/noc_input_port.sv
// Router input port: buffers PE flits, returns one credit per drained flit, and keeps a
// saturating receive counter plus a sticky overflow flag for debug.
module noc_input_port
  import noc_pkg::*;
#(
  parameter int unsigned FLIT_W = noc_pkg::FLIT_W,
  parameter int unsigned DEPTH  = noc_pkg::DEPTH,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [FLIT_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     ci,
  output logic [FLIT_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     ovf,
  output logic [CNT_W-1:0]         rx_count
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic full, empty;
  logic push, pop, drop;
  logic ci_q, ovf_q, ovf_d;
  logic [CNT_W-1:0] rx_count_q, rx_count_d;

  noc_flit_fifo #(
    .FLIT_W (FLIT_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .wdata     (in_data),
    .rdata     (out_data),
    .full      (full),
    .empty     (empty),
    .occupancy (occupancy)
  );

  // Handshake decode; a pop frees a slot in the same cycle so a full buffer still accepts.
  always_comb begin
    pop  = !empty && out_ready;
    push = in_valid && (!full || pop);
    drop = in_valid && full && !pop;
  end

  // Debug state next values: sticky overflow, saturating accepted-flit counter.
  always_comb begin
    ovf_d      = ovf_q | drop;
    rx_count_d = rx_count_q;
    if (push && (rx_count_q != '1)) rx_count_d = rx_count_q + CntOne;
  end

  // Credit return lags the pop by one clock; reset discards pending credits.
  always_ff @(posedge clk) begin
    if (rst) begin
      ci_q       <= 1'b0;
      ovf_q      <= 1'b0;
      rx_count_q <= '0;
    end else begin
      ci_q       <= pop;
      ovf_q      <= ovf_d;
      rx_count_q <= rx_count_d;
    end
  end

  assign ci        = ci_q;
  assign out_valid = !empty;
  assign ovf       = ovf_q;
  assign rx_count  = rx_count_q;

endmodule

// File: tb/tb_noc_input_port.sv
// Directed bench for noc_input_port with a reference queue model and a PE credit model.
module tb_noc_input_port;
  import noc_pkg::*;

  localparam int unsigned Depth = 8;
  localparam int unsigned CntW  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [FLIT_W-1:0] in_data;
  logic              in_valid;
  logic              ci;
  logic [FLIT_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        occupancy;
  logic              ovf;
  logic [CntW-1:0]   rx_count;

  int tests_run = 0;
  int tests_failed = 0;
  int ci_total = 0;
  int pop_total = 0;
  flit_t model_q[$];

  noc_input_port #(
    .FLIT_W (FLIT_W),
    .DEPTH  (Depth),
    .CNT_W  (CntW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .ci        (ci),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .occupancy (occupancy),
    .ovf       (ovf),
    .rx_count  (rx_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: ordered queue, checks every popped flit and the valid flag.
  always @(posedge clk) begin
    bit model_full;
    bit pop_now;
    if (ci) ci_total++;
    if (rst) begin
      model_q.delete();
    end else begin
      model_full = (model_q.size() >= Depth);
      pop_now    = out_valid && out_ready;
      check("out_valid_vs_model", {63'd0, out_valid}, {63'd0, model_q.size() != 0});
      if (pop_now && model_q.size() != 0) begin
        pop_total++;
        check("pop_data", {44'd0, out_data}, {44'd0, model_q.pop_front()});
      end
      if (in_valid && (!model_full || pop_now)) model_q.push_back(in_data);
    end
  end

  initial begin
    int ci_before;
    int credits;
    int pushes;

    rst = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_ci", {63'd0, ci}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_occupancy", {60'd0, occupancy}, 64'd0);
    check("rst_ovf", {63'd0, ovf}, 64'd0);
    check("rst_rx_count", {48'd0, rx_count}, 64'd0);

    // Single flit: visible the cycle after push, credit one cycle after pop.
    in_data = 20'h0ABCD; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("single_valid", {63'd0, out_valid}, 64'd1);
    check("single_data", {44'd0, out_data}, 64'h0ABCD);
    check("single_ci_early", {63'd0, ci}, 64'd0);
    check("single_rx", {48'd0, rx_count}, 64'd1);
    tick();
    check("single_ci", {63'd0, ci}, 64'd1);
    check("single_occ", {60'd0, occupancy}, 64'd0);
    tick();
    check("single_ci_once", {63'd0, ci}, 64'd0);

    // Fill eight with the router stalled.
    out_ready = 1'b0;
    ci_before = ci_total;
    for (int i = 1; i <= 8; i++) begin
      in_data = FLIT_W'(i); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("fill_occ", {60'd0, occupancy}, 64'd8);
    check("fill_ovf", {63'd0, ovf}, 64'd0);
    check("fill_no_ci", ci_total, ci_before);
    check("fill_rx", {48'd0, rx_count}, 64'd9);

    // Ninth flit into a full buffer is dropped.
    in_data = 20'h12345; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("drop_ovf", {63'd0, ovf}, 64'd1);
    check("drop_rx", {48'd0, rx_count}, 64'd9);
    check("drop_occ", {60'd0, occupancy}, 64'd8);

    // Drain in order; each credit follows its pop by one cycle.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check("drain_data", {44'd0, out_data}, 64'(i));
      tick();
      check("drain_ci", {63'd0, ci}, 64'd1);
    end
    tick();
    check("drain_ci_end", {63'd0, ci}, 64'd0);
    check("drain_occ", {60'd0, occupancy}, 64'd0);
    check("drain_ovf_sticky", {63'd0, ovf}, 64'd1);

    // Reset clears the sticky flag.
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst2_ovf", {63'd0, ovf}, 64'd0);

    // Full buffer with simultaneous push and pop across pointer wrap.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_data = FLIT_W'(32'h100 + i); in_valid = 1'b1;
      tick();
    end
    out_ready = 1'b1;
    ci_before = ci_total;
    for (int i = 0; i < 20; i++) begin
      in_data = FLIT_W'(32'h200 + i);
      tick();
      check("stream_occ", {60'd0, occupancy}, 64'd8);
    end
    in_valid = 1'b0;
    tick();
    check("stream_ci", ci_total - ci_before, 20);
    check("stream_ovf", {63'd0, ovf}, 64'd0);
    for (int i = 0; i < 12 && out_valid; i++) tick();
    tick();
    check("stream_empty", {60'd0, occupancy}, 64'd0);

    // Random traffic under a seven-credit PE model.
    rst = 1'b1; tick(); rst = 1'b0;
    credits = PE_CREDITS; pushes = 0; ci_before = ci_total;
    pop_total = 0;
    for (int i = 0; i < 1000; i++) begin
      in_valid  = (credits > 0) && ($urandom_range(1, 0) == 1);
      in_data   = FLIT_W'($urandom);
      out_ready = ($urandom_range(1, 0) == 1);
      if (in_valid) begin credits--; pushes++; end
      tick();
      if (ci) credits++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ci) credits++;
    end
    check("rand_ovf", {63'd0, ovf}, 64'd0);
    check("rand_credits", credits, PE_CREDITS);
    check("rand_ci_vs_pop", ci_total - ci_before, pop_total);
    check("rand_pops", pop_total, pushes);
    check("rand_rx", {48'd0, rx_count}, 64'(pushes));

    // Reset with five flits held: contents discarded, no credits for them.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_data = FLIT_W'(32'h300 + i); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check("pre_rst_occ", {60'd0, occupancy}, 64'd5);
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_data = 20'h0FFFF;
    ci_before = ci_total;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_occ", {60'd0, occupancy}, 64'd0);
    check("mid_rst_rx", {48'd0, rx_count}, 64'd0);
    check("mid_rst_ovf", {63'd0, ovf}, 64'd0);
    tick(); tick();
    check("mid_rst_no_ci", ci_total, ci_before);
    check("mid_rst_still_empty", {63'd0, out_valid}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
